// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared state encoding and default timing for the operand loader
//
// Holds the FSM state type (S_A=0, S_B=1, S_SHOW=2; code 3 unused), the default
// debounce length and counter width, and the state-to-LED one-hot mapping.
// No ports. OPLOAD_BTN_SYNC_EN is consumed by btn_debounce, not here.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  // 10 ms at 50 MHz; 2^19 > 500000.
  localparam int DB_CYCLES_DEF = 500000;
  localparam int DB_W_DEF      = 19;

  function automatic logic [2:0] step_onehot(state_t s);
    case (s)
      S_A:     step_onehot = 3'b001;
      S_B:     step_onehot = 3'b010;
      S_SHOW:  step_onehot = 3'b100;
      default: step_onehot = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// rtl/operand_loader_btn_debounce.sv - button synchronizer, debouncer and rising-edge detector
//
// Ports:
//   mclk   in   master clock, rising edge
//   rs     in   synchronous active-low reset
//   btn    in   raw bouncing push-button, active-high
//   press  out  one-cycle pulse per debounced rising edge
// Macro OPLOAD_BTN_SYNC_EN: when defined, btn passes through two flops first.
module btn_debounce
  import operand_loader_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic mclk,
  input  logic rs,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_TOP = DB_W'(DB_CYCLES - 1);

  logic            btn_s;
  logic [DB_W-1:0] cnt;
  logic            btn_db;
  logic            btn_db_q;

`ifdef OPLOAD_BTN_SYNC_EN
  logic sync0;
  logic sync1;

  always_ff @(posedge mclk) begin
    if (!rs) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
    end
  end

  assign btn_s = sync1;
`else
  assign btn_s = btn;
`endif

  always_ff @(posedge mclk) begin
    if (!rs) begin
      cnt      <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      // Registered so the FSM sees press straight from a flop; only the
      // rising edge of the debounced level counts, release is ignored.
      press    <= btn_db & ~btn_db_q;
      if (btn_s != btn_db) begin
        // Any matching sample restarts the count, so short glitches never
        // get through.
        if (cnt == CNT_TOP) begin
          btn_db <= btn_s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - two-step operand capture (A then B) from shared switches
//
// Ports:
//   mclk        in   master clock, rising edge
//   rs          in   synchronous active-low reset
//   sw[3:0]     in   operand switches, quasi-static
//   btn         in   raw push-button, active-high
//   a_out[3:0]  out  registered operand A
//   b_out[3:0]  out  registered operand B
//   ab_valid    out  high while in S_SHOW
//   load_pulse  out  one cycle, concurrent with the new b_out
//   step_led    out  one-hot state {S_SHOW, S_B, S_A}
// Macro OPLOAD_BTN_SYNC_EN: enables the two-flop button synchronizer.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic       mclk,
  input  logic       rs,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       ab_valid,
  output logic       load_pulse,
  output logic [2:0] step_led
);

  logic       press;
  state_t     state;
  state_t     state_next;
  logic [3:0] a_next;
  logic [3:0] b_next;
  logic       load_next;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W)
  ) u_btn_debounce (
    .mclk (mclk),
    .rs   (rs),
    .btn  (btn),
    .press(press)
  );

  always_comb begin
    state_next = state;
    a_next     = a_out;
    b_next     = b_out;
    load_next  = 1'b0;
    case (state)
      S_A: begin
        if (press) begin
          a_next     = sw;
          state_next = S_B;
        end
      end
      S_B: begin
        if (press) begin
          b_next     = sw;
          state_next = S_SHOW;
          load_next  = 1'b1;
        end
      end
      S_SHOW: begin
        // Operands are kept so the adder output stays meaningful until the
        // next A capture.
        if (press) state_next = S_A;
      end
      default: state_next = S_A;  // unused code 3: recover, no writes
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rs) begin
      state      <= S_A;
      a_out      <= 4'd0;
      b_out      <= 4'd0;
      ab_valid   <= 1'b0;
      load_pulse <= 1'b0;
      step_led   <= 3'b001;
    end else begin
      state      <= state_next;
      a_out      <= a_next;
      b_out      <= b_next;
      // Derived from next state so the indicators change on the capture edge.
      ab_valid   <= (state_next == S_SHOW);
      load_pulse <= load_next;
      step_led   <= step_onehot(state_next);
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - scoreboard bench for operand_loader
module tb_operand_loader;

  localparam int DB = 4;
`ifdef OPLOAD_BTN_SYNC_EN
  localparam int CAP = DB + 3;
`else
  localparam int CAP = DB + 1;
`endif

  logic       clk = 1'b0;
  logic       rs;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       ab_valid;
  logic       load_pulse;
  logic [2:0] step_led;

  operand_loader #(.DB_CYCLES(DB), .DB_W(3)) dut (
    .mclk      (clk),
    .rs        (rs),
    .sw        (sw),
    .btn       (btn),
    .a_out     (a_out),
    .b_out     (b_out),
    .ab_valid  (ab_valid),
    .load_pulse(load_pulse),
    .step_led  (step_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [2:0] led;
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic       lp;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lp_count = 0;
  bit   mon_en   = 0;
  logic [2:0] prev_led = 3'b001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a step_led change is one DUT response; pop and compare it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (step_led !== prev_led) begin
        if (q.size() == 0) begin
          chk("unexpected_state_change", {29'd0, step_led}, {29'd0, prev_led});
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("step_led", {29'd0, step_led}, {29'd0, e.led});
          chk("a_out", {28'd0, a_out}, {28'd0, e.a});
          chk("b_out", {28'd0, b_out}, {28'd0, e.b});
          chk("ab_valid", {31'd0, ab_valid}, {31'd0, e.v});
          chk("load_pulse", {31'd0, load_pulse}, {31'd0, e.lp});
          chk("event_cycle", cyc, e.at);
        end
      end else if (load_pulse === 1'b1) begin
        chk("stray_load_pulse", {31'd0, load_pulse}, 32'd0);
      end
      if (load_pulse === 1'b1) lp_count++;
      prev_led = step_led;
    end
  end

  task automatic push(input logic [2:0] led, input logic [3:0] a, input logic [3:0] b,
                      input logic v, input logic lp, input int at);
    exp_t e;
    e.led = led; e.a = a; e.b = b; e.v = v; e.lp = lp; e.at = at;
    q.push_back(e);
  endtask

  task automatic do_press(input logic [3:0] v, input int hold, input int rel,
                          input logic [2:0] e_led, input logic [3:0] e_a,
                          input logic [3:0] e_b, input logic e_v, input logic e_lp);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    push(e_led, e_a, e_b, e_v, e_lp, cyc + 1 + CAP);
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  initial begin
    rs  = 1'b0;
    btn = 1'b0;
    sw  = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_a_out", {28'd0, a_out}, 32'd0);
    chk("rst_b_out", {28'd0, b_out}, 32'd0);
    chk("rst_ab_valid", {31'd0, ab_valid}, 32'd0);
    chk("rst_load_pulse", {31'd0, load_pulse}, 32'd0);
    chk("rst_step_led", {29'd0, step_led}, 32'd1);
    mon_en = 1;
    rs     = 1'b1;

    // Normal entry, then a switch change outside capture must not matter.
    do_press(4'hA, 10, 15, 3'b010, 4'hA, 4'h0, 1'b0, 1'b0);
    sw = 4'h5;
    repeat (5) @(negedge clk);
    do_press(4'h7, 10, 15, 3'b100, 4'hA, 4'h7, 1'b1, 1'b1);

    // Wrap back to S_A keeps both operands.
    do_press(4'h3, 10, 15, 3'b001, 4'hA, 4'h7, 1'b0, 1'b0);

    // Bounce: 2-cycle pulses never reach the debounce threshold.
    sw = 4'hE;
    repeat (5) begin
      btn = 1'b1;
      repeat (2) @(negedge clk);
      btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("bounce_step_led", {29'd0, step_led}, 32'd1);
    chk("bounce_a_out", {28'd0, a_out}, 32'hA);

    // Held button: exactly one capture.
    do_press(4'h9, 100, 15, 3'b010, 4'h9, 4'h7, 1'b0, 1'b0);
    chk("held_step_led", {29'd0, step_led}, 32'd2);

    // Reset mid-entry discards A immediately.
    @(negedge clk);
    rs = 1'b0;
    push(3'b001, 4'h0, 4'h0, 1'b0, 1'b0, cyc + 1);
    @(negedge clk);
    rs = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_a_out", {28'd0, a_out}, 32'd0);
    chk("midrst_step_led", {29'd0, step_led}, 32'd1);

    // Button held through reset release counts as a new press.
    @(negedge clk);
    sw  = 4'hC;
    btn = 1'b1;
    rs  = 1'b0;
    repeat (2) @(negedge clk);
    rs = 1'b1;
    push(3'b010, 4'hC, 4'h0, 1'b0, 1'b0, cyc + 1 + CAP);
    repeat (30) @(negedge clk);
    btn = 1'b0;
    repeat (15) @(negedge clk);

    chk("final_step_led", {29'd0, step_led}, 32'd2);
    chk("final_a_out", {28'd0, a_out}, 32'hC);
    chk("pending_events", q.size(), 32'd0);
    chk("load_pulse_count", lp_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
